// File: rtl/lsu_dmem_ctrl_if.sv
// Request/response and data-memory signals of the load/store unit, grouped as one bundle.
// The master modport is the LSU's view; the slave modport is the pipeline/memory side.
interface lsu_dmem_ctrl_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32
);
    logic               i_req_valid;
    logic               o_req_ready;
    logic               i_req_we;
    logic [2:0]         i_req_funct3;
    logic [NB_ADDR-1:0] i_req_addr;
    logic [NB_DATA-1:0] i_req_wdata;
    logic               o_rsp_valid;
    logic [NB_DATA-1:0] o_rsp_rdata;
    logic               o_rsp_error;
    logic [NB_ADDR-1:0] o_dmem_address;
    logic               o_dmem_wr_enable;
    logic [NB_DATA-1:0] o_dmem_wr_data;
    logic [NB_DATA-1:0] i_dmem_rd_data;

    modport master (
        input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_dmem_rd_data,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error,
        output o_dmem_address, o_dmem_wr_enable, o_dmem_wr_data
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_dmem_rd_data,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error,
        input  o_dmem_address, o_dmem_wr_enable, o_dmem_wr_data
    );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// RV32I load/store initiator: word-aligned dmem access, read-modify-write for SB/SH, load extension.
// Optional macro LSU_DMEM_ERR_CNT_EN adds a saturating error-response counter o_err_count.
module lsu_dmem_ctrl #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    lsu_dmem_ctrl_if.master     bus
`ifdef LSU_DMEM_ERR_CNT_EN
    ,
    output logic [15:0]         o_err_count
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_e;

    state_e             state_q, state_d;
    logic [1:0]         addr_q, addr_d;
    logic               we_q, we_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [NB_DATA-1:0] wdata_q, wdata_d;
    logic [NB_ADDR-1:0] daddr_q, daddr_d;
    logic [NB_DATA-1:0] merged_q, merged_d;
    logic [NB_DATA-1:0] rdata_q, rdata_d;
    logic               error_q, error_d;

    logic               req_legal;
    logic               req_misal;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [NB_DATA-1:0] load_ext;
    logic [NB_DATA-1:0] merge_word;

    always_comb begin
        req_legal = 1'b0;
        req_misal = 1'b0;
        case (bus.i_req_funct3)
            3'b000:         req_legal = 1'b1;
            3'b001: begin
                req_legal = 1'b1;
                req_misal = bus.i_req_addr[0];
            end
            3'b010: begin
                req_legal = 1'b1;
                req_misal = |bus.i_req_addr[1:0];
            end
            3'b100, 3'b101: begin
                req_legal = !bus.i_req_we;
                req_misal = bus.i_req_funct3[0] & bus.i_req_addr[0];
            end
            default: ;
        endcase
    end

    // Load lane selection and sign/zero extension (funct3[2] set means unsigned).
    always_comb begin
        byte_sel = 8'h00;
        case (addr_q)
            2'd0:    byte_sel = bus.i_dmem_rd_data[7:0];
            2'd1:    byte_sel = bus.i_dmem_rd_data[15:8];
            2'd2:    byte_sel = bus.i_dmem_rd_data[23:16];
            default: byte_sel = bus.i_dmem_rd_data[31:24];
        endcase
        half_sel = addr_q[1] ? bus.i_dmem_rd_data[31:16] : bus.i_dmem_rd_data[15:0];
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
            2'b01:   load_ext = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
            default: load_ext = bus.i_dmem_rd_data;
        endcase
    end

    // Per-lane merge for SB/SH: SH writes wdata[15:0] into the half picked by addr[1].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = gi[1:0];
            logic lane_hit;
            assign lane_hit = funct3_q[0] ? (addr_q[1] == LANE[1]) : (addr_q == LANE);
            assign merge_word[gi*8 +: 8] = !lane_hit ? bus.i_dmem_rd_data[gi*8 +: 8] :
                                           funct3_q[0] ? wdata_q[(gi%2)*8 +: 8] : wdata_q[7:0];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        daddr_d  = daddr_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    addr_d   = bus.i_req_addr[1:0];
                    we_d     = bus.i_req_we;
                    funct3_d = bus.i_req_funct3;
                    wdata_d  = bus.i_req_wdata;
                    if (!req_legal || req_misal) begin
                        error_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        daddr_d = {bus.i_req_addr[NB_ADDR-1:2], 2'b00};
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_ext;
                    state_d = RESP;
                end else if (funct3_q[1]) begin
                    state_d = RESP;
                end else begin
                    merged_d = merge_word;
                    state_d  = MERGE_WR;
                end
            end
            MERGE_WR: state_d = RESP;
            default: begin
                rdata_d = '0;
                error_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            wdata_q  <= '0;
            daddr_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            daddr_q  <= daddr_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    assign bus.o_req_ready      = (state_q == IDLE);
    assign bus.o_rsp_valid      = (state_q == RESP);
    assign bus.o_rsp_rdata      = rdata_q;
    assign bus.o_rsp_error      = error_q;
    assign bus.o_dmem_address   = daddr_q;
    assign bus.o_dmem_wr_enable = ((state_q == ACCESS) && we_q && funct3_q[1]) || (state_q == MERGE_WR);
    assign bus.o_dmem_wr_data   = (state_q == MERGE_WR) ? merged_q :
                                  (state_q == ACCESS)   ? wdata_q  : '0;

`ifdef LSU_DMEM_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_cnt_q <= '0;
        end else if ((state_q == RESP) && error_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign o_err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed vector bench for lsu_dmem_ctrl with a small word-addressed data memory model.
module tb_lsu_dmem_ctrl;
    logic clk;
    logic rst_n;

    lsu_dmem_ctrl_if #(.NB_DATA(32), .NB_ADDR(32)) bus ();

`ifdef LSU_DMEM_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    lsu_dmem_ctrl #(.NB_DATA(32), .NB_ADDR(32)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus.master)
`ifdef LSU_DMEM_ERR_CNT_EN
        ,
        .o_err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, clocked full-word write, plus a preload port.
    logic [31:0] mem [0:255];
    logic        pl_we;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_data;
        else if (bus.o_dmem_wr_enable) mem[bus.o_dmem_address[9:2]] <= bus.o_dmem_wr_data;
    end
    assign bus.i_dmem_rd_data = mem[bus.o_dmem_address[9:2]];

    int n_pass  = 0;
    int n_total = 0;
    int exp_err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pl_idx  = addr[9:2];
        pl_data = data;
        pl_we   = 1'b1;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rd, input logic err,
                                input int lat, input int wr);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat; v.exp_wr = wr;
        return v;
    endfunction

    localparam int NV = 22;
    vec_t vecs [0:NV-1];

    // Waits (bounded) for the response after an accept edge, then checks it and the idle cycle after.
    task automatic wait_rsp(input int idx, input vec_t v);
        int lat, wr;
        logic got;
        logic [31:0] rdata, waddr;
        logic err;
        lat = 0; wr = 0; got = 1'b0; rdata = '0; err = 1'b0; waddr = '0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (bus.o_dmem_wr_enable) begin
                wr++;
                waddr = bus.o_dmem_address;
            end
            if (bus.o_rsp_valid) begin
                got   = 1'b1;
                lat   = c;
                rdata = bus.o_rsp_rdata;
                err   = bus.o_rsp_error;
            end
        end
        $display("vec %0d: we=%0b f3=%0b addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b writes=%0d",
                 idx, v.we, v.f3, v.addr, v.wdata, lat, rdata, err, wr);
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        check($sformatf("v%0d error", idx), {31'd0, err}, {31'd0, v.exp_err});
        check($sformatf("v%0d writes", idx), wr, v.exp_wr);
        if (v.exp_wr > 0) check($sformatf("v%0d wr_addr", idx), waddr, {v.addr[31:2], 2'b00});
        @(negedge clk);
        check($sformatf("v%0d rsp_valid_after", idx), {31'd0, bus.o_rsp_valid}, 32'd0);
        check($sformatf("v%0d rdata_cleared", idx), bus.o_rsp_rdata, 32'd0);
        check($sformatf("v%0d error_cleared", idx), {31'd0, bus.o_rsp_error}, 32'd0);
        check($sformatf("v%0d ready_after", idx), {31'd0, bus.o_req_ready}, 32'd1);
`ifdef LSU_DMEM_ERR_CNT_EN
        if (v.exp_err) exp_err_cnt++;
        check($sformatf("v%0d err_count", idx), {16'd0, err_count}, exp_err_cnt);
`endif
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        check($sformatf("v%0d ready_idle", idx), {31'd0, bus.o_req_ready}, 32'd1);
        bus.i_req_we     = v.we;
        bus.i_req_funct3 = v.f3;
        bus.i_req_addr   = v.addr;
        bus.i_req_wdata  = v.wdata;
        bus.i_req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_req_valid  = 1'b0;
        bus.i_req_we     = $urandom_range(0, 1);
        bus.i_req_funct3 = 3'($urandom_range(0, 7));
        bus.i_req_addr   = $urandom;
        bus.i_req_wdata  = $urandom;
        wait_rsp(idx, v);
    endtask

    initial begin
        vec_t v;
        // Word 0x100 starts as 8899AABB; later stores modify it and the following loads depend on that.
        vecs[0]  = mk(0, 3'b000, 32'h103, 32'h0,        32'hFFFFFF88, 0, 2, 0); // LB
        vecs[1]  = mk(0, 3'b101, 32'h102, 32'h0,        32'h00008899, 0, 2, 0); // LHU
        vecs[2]  = mk(0, 3'b001, 32'h100, 32'h0,        32'hFFFFAABB, 0, 2, 0); // LH
        vecs[3]  = mk(0, 3'b100, 32'h100, 32'h0,        32'h000000BB, 0, 2, 0); // LBU
        vecs[4]  = mk(1, 3'b000, 32'h101, 32'h12345677, 32'h0,        0, 3, 1); // SB
        vecs[5]  = mk(0, 3'b010, 32'h100, 32'h0,        32'h889977BB, 0, 2, 0); // LW
        vecs[6]  = mk(1, 3'b010, 32'h102, 32'h55555555, 32'h0,        1, 1, 0); // SW misaligned
        vecs[7]  = mk(0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 1, 0); // illegal load
        vecs[8]  = mk(1, 3'b100, 32'h100, 32'hFFFFFFFF, 32'h0,        1, 1, 0); // illegal store
        vecs[9]  = mk(0, 3'b010, 32'h100, 32'h0,        32'h889977BB, 0, 2, 0); // unchanged
        vecs[10] = mk(1, 3'b001, 32'h102, 32'hCAFE1234, 32'h0,        0, 3, 1); // SH upper half
        vecs[11] = mk(0, 3'b010, 32'h100, 32'h0,        32'h123477BB, 0, 2, 0);
        vecs[12] = mk(0, 3'b001, 32'h101, 32'h0,        32'h0,        1, 1, 0); // LH misaligned
        vecs[13] = mk(1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        0, 2, 1); // SW
        vecs[14] = mk(0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 0, 2, 0);
        vecs[15] = mk(0, 3'b000, 32'h106, 32'h0,        32'hFFFFFFAD, 0, 2, 0); // LB lane 2
        vecs[16] = mk(0, 3'b101, 32'h106, 32'h0,        32'h0000DEAD, 0, 2, 0);
        vecs[17] = mk(0, 3'b001, 32'h104, 32'h0,        32'hFFFFBEEF, 0, 2, 0);
        vecs[18] = mk(0, 3'b010, 32'h101, 32'h0,        32'h0,        1, 1, 0); // LW misaligned
        vecs[19] = mk(0, 3'b110, 32'h100, 32'h0,        32'h0,        1, 1, 0); // illegal load
        vecs[20] = mk(0, 3'b100, 32'h103, 32'h0,        32'h00000012, 0, 2, 0); // LBU
        vecs[21] = mk(0, 3'b000, 32'h102, 32'h0,        32'h00000034, 0, 2, 0); // LB positive

        rst_n = 1'b0;
        pl_we = 1'b0; pl_idx = '0; pl_data = '0;
        bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_funct3 = '0;
        bus.i_req_addr = '0; bus.i_req_wdata = '0;
        preload(32'h100, 32'h8899AABB);
        preload(32'h104, 32'h00000000);
        preload(32'h108, 32'h11223344);

        #1;
        check("reset ready", {31'd0, bus.o_req_ready}, 32'd1);
        check("reset rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
        check("reset rdata", bus.o_rsp_rdata, 32'd0);
        check("reset error", {31'd0, bus.o_rsp_error}, 32'd0);
        check("reset wr_enable", {31'd0, bus.o_dmem_wr_enable}, 32'd0);
        check("reset address", bus.o_dmem_address, 32'd0);
        check("reset wr_data", bus.o_dmem_wr_data, 32'd0);
`ifdef LSU_DMEM_ERR_CNT_EN
        check("reset err_count", {16'd0, err_count}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Reset during MERGE_WR of an SH, with i_req_valid held high throughout.
        @(negedge clk);
        bus.i_req_we = 1'b1; bus.i_req_funct3 = 3'b001;
        bus.i_req_addr = 32'h10A; bus.i_req_wdata = 32'h0000BEEF;
        bus.i_req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_req_we = 1'b0; bus.i_req_funct3 = 3'b010;
        bus.i_req_addr = 32'h108; bus.i_req_wdata = 32'h0;
        @(negedge clk);
        check("busy ready", {31'd0, bus.o_req_ready}, 32'd0);
        @(negedge clk);
        check("merge wr_enable", {31'd0, bus.o_dmem_wr_enable}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        $display("mid-reset: wr_enable=%0b ready=%0b", bus.o_dmem_wr_enable, bus.o_req_ready);
        check("async wr_enable drop", {31'd0, bus.o_dmem_wr_enable}, 32'd0);
        check("async ready", {31'd0, bus.o_req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("word unchanged", mem[8'h42], 32'h11223344);
        rst_n = 1'b1;
        exp_err_cnt = 0;
        @(posedge clk);
        #1 bus.i_req_valid = 1'b0;
        v = mk(0, 3'b010, 32'h108, 32'h0, 32'h11223344, 0, 2, 0);
        wait_rsp(NV, v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
- Load/store initiator that drives the data-memory port on behalf of the execute stage.
- The memory has a combinational word read and a clocked full-word write only. This block therefore:
  - word-aligns all accesses,
  - performs read-modify-write for SB/SH,
  - byte/half-selects and sign/zero-extends load data,
  - flags misaligned or illegal requests without touching memory.
- Sits between the EX/MEM pipeline stage and the dmem.

Parameters:
- NB_DATA, 32, data word width (fixed 32 for RV32I).
- NB_ADDR, 32, byte address width.

Ports:
- i_clock  input  1  system clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  block can accept a request.
- i_req_we  input  1  1 = store, 0 = load.
- i_req_funct3  input  3  RV32I funct3 (size/sign).
- i_req_addr  input  NB_ADDR  byte address.
- i_req_wdata  input  NB_DATA  store data (LSB-justified).
- o_rsp_valid  output  1  one-cycle response pulse.
- o_rsp_rdata  output  NB_DATA  extended load data; 0 for stores/errors.
- o_rsp_error  output  1  misaligned or illegal funct3.
- o_dmem_address  output  NB_ADDR  word-aligned address {addr[NB_ADDR-1:2],2'b00}.
- o_dmem_wr_enable  output  1  write strobe to dmem.
- o_dmem_wr_data  output  NB_DATA  full word to write.
- i_dmem_rd_data  input  NB_DATA  combinational read data for o_dmem_address.

Behaviour:
- Clock and reset: one clock i_clock; reset i_reset_n is asynchronous, active-low.
- Reset values: state=IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_error=0, o_dmem_wr_enable=0, o_dmem_address=0, o_dmem_wr_data=0, all captured registers=0.
- Reset mid-operation: returns to IDLE immediately; wr_enable deasserts asynchronously; any pending RMW is abandoned (no partial write).
- Handshake:
  - Accept on posedge with i_req_valid && o_req_ready.
  - o_req_ready=1 only in IDLE.
  - Request fields are captured on accept and need not be held afterwards.
- Legal encodings:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other encoding is illegal.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
- FSM states: IDLE, ACCESS, MERGE_WR, RESP.
  - IDLE, on accept:
    - illegal or misaligned -> RESP with error=1, no dmem access;
    - otherwise -> ACCESS.
  - ACCESS: drives o_dmem_address from the captured address.
    - Load: select byte/half via addr[1:0] (half via addr[1]), extend (signed for 000/001), register into rsp_rdata -> RESP.
    - SW: wr_enable=1, wr_data=wdata -> RESP.
    - SB/SH: register i_dmem_rd_data with the target lane(s) replaced by wdata[7:0]/[15:0] -> MERGE_WR.
  - MERGE_WR: same address, wr_enable=1, wr_data=merged word -> RESP.
  - RESP: o_rsp_valid=1 for exactly one cycle -> IDLE.
- Latency (accept edge = N):
  - error: rsp_valid in cycle N+1;
  - loads and SW: N+2;
  - SB/SH: N+3.
- Throughput: one request in flight; no back-to-back accept; ready returns in the cycle after RESP.
- o_dmem_wr_enable is high only in ACCESS(SW) or MERGE_WR, never in IDLE/RESP.
- o_dmem_address holds its last value in IDLE (no glitch requirement beyond that).
- o_rsp_rdata and o_rsp_error are valid only while o_rsp_valid=1; both are cleared to 0 after RESP.
- Addresses within 3 bytes of the memory top are the user's responsibility; no wrap handling.

Optional Feature:
- Macro: LSU_DMEM_ERR_CNT_EN.
- Defined:
  - adds output o_err_count [15:0];
  - increments on every error response;
  - saturates at 16'hFFFF;
  - reset 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Preload word 0x100 = 0x8899AABB; LB addr 0x103 -> rsp_valid at N+2, rdata=0xFFFFFF88, error=0, no wr_enable.
- Same word; LHU addr 0x102 -> rdata=0x00008899; LH addr 0x100 -> rdata=0xFFFFAABB.
- SB addr 0x101, wdata=0x12345677 -> one write at N+2 of 0x8899_77BB to 0x100; rsp_valid at N+3; later LW 0x100 returns 0x889977BB.
- SW addr 0x102 (misaligned) -> rsp_valid N+1, error=1, rdata=0, wr_enable never asserted; with LSU_DMEM_ERR_CNT_EN, o_err_count 0->1.
- funct3=3'b011 load -> error=1; store with funct3=3'b100 -> error=1; memory unchanged.
- Assert i_reset_n=0 during MERGE_WR of SH -> wr_enable drops immediately, word unchanged, ready=1 after release; i_req_valid held high throughout -> second request accepted only in IDLE.
